// File: rtl/barrel_shift_l_pipe_if.sv
// Stream interface for the pipelined left barrel shifter/rotator.
//
// Carries both handshakes of the block:
//   in_valid  / in_ready  : operand channel (num, amt, rotate)
//   out_valid / out_ready : result channel (shifted)
//
// Modports:
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : shifter side (drives in_ready, out_valid, shifted)
//
// Parameters:
//   ADDRESS_BITS : shift-amount width; data width is 2**ADDRESS_BITS.
interface barrel_shift_l_pipe_if #(
  parameter int unsigned ADDRESS_BITS = 3
) ();

  localparam int unsigned WIDTH = 2 ** ADDRESS_BITS;

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        num;
  logic [ADDRESS_BITS-1:0] amt;
  logic                    rotate;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        shifted;

  modport master (
    output in_valid,
    output num,
    output amt,
    output rotate,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  shifted
  );

  modport slave (
    input  in_valid,
    input  num,
    input  amt,
    input  rotate,
    input  out_ready,
    output in_ready,
    output out_valid,
    output shifted
  );

endinterface

// File: rtl/barrel_shift_l_pipe.sv
// Pipelined left barrel shifter / rotator.
//
// One registered stage per shift-amount bit. Stage k (0-based) applies amt bit k, moving the
// operand left by 2**k positions, either wrapping the MSBs into the LSBs (rotate=1) or zero
// filling (rotate=0). Each stage carries its own valid bit so the chain compacts bubbles and
// sustains one item per cycle with full backpressure.
//
// Ports:
//   clk        : clock, all state on the rising edge
//   reset      : synchronous, active-high; clears every stage
//   bus        : barrel_shift_l_pipe_if.slave
//                  in_valid/in_ready/num/amt/rotate  operand channel
//                  out_valid/out_ready/shifted       result channel
//   occupancy  : (only with BSL_OCCUPANCY_EN defined) number of valid stages, registered
//
// Optional feature macro: BSL_OCCUPANCY_EN
//
// Parameters:
//   ADDRESS_BITS : shift-amount width and pipeline depth. WIDTH = 2**ADDRESS_BITS is fixed.
module barrel_shift_l_pipe #(
  parameter int unsigned ADDRESS_BITS = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
`ifdef BSL_OCCUPANCY_EN
  output logic [$clog2(ADDRESS_BITS + 1) - 1:0]  occupancy,
`endif
  barrel_shift_l_pipe_if.slave                   bus
);

  localparam int unsigned WIDTH = 2 ** ADDRESS_BITS;
  localparam int unsigned N     = ADDRESS_BITS;

  // Registered state of every stage, gathered for the ready chain and the output.
  logic [N-1:0]     stage_valid;
  logic [WIDTH-1:0] stage_data [N];
  logic [N-1:0]     stage_amt  [N];
  logic [N-1:0]     stage_rot;

  // ready[k] is the ready of stage k (0-based); ready[N] is the downstream ready.
  // A stage can load when it is empty or when every stage after it can move. Written in
  // closed form (out_ready OR any later/own stage empty) so there is no combinational
  // self-reference through the vector.
  logic [N:0] ready;

  always_comb begin
    ready = '0;
    for (int k = 0; k <= int'(N); k++) begin
      ready[k] = bus.out_ready;
      for (int j = k; j < int'(N); j++) begin
        if (!stage_valid[j]) begin
          ready[k] = 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int unsigned Sh = 2 ** k;

    logic             v_in;
    logic             r_in;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic [N-1:0]     a_in;

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [N-1:0]     amt_q;
    logic             rot_q;

    if (k == 0) begin : g_src_port
      assign v_in = bus.in_valid;
      assign d_in = bus.num;
      assign a_in = bus.amt;
      assign r_in = bus.rotate;
    end else begin : g_src_stage
      assign v_in = stage_valid[k-1];
      assign d_in = stage_data[k-1];
      assign a_in = stage_amt[k-1];
      assign r_in = stage_rot[k-1];
    end

    // Fixed-distance shift for this stage; the rotate term recovers the bits pushed off the top.
    always_comb begin
      d_out = d_in;
      if (a_in[k]) begin
        if (r_in) begin
          d_out = (d_in << Sh) | (d_in >> (WIDTH - Sh));
        end else begin
          d_out = d_in << Sh;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        amt_q   <= '0;
        rot_q   <= 1'b0;
      end else if (ready[k]) begin
        valid_q <= v_in;
        data_q  <= d_out;
        amt_q   <= a_in;
        rot_q   <= r_in;
      end
    end

    assign stage_valid[k] = valid_q;
    assign stage_data[k]  = data_q;
    assign stage_amt[k]   = amt_q;
    assign stage_rot[k]   = rot_q;
  end

  assign bus.in_ready  = ready[0];
  assign bus.out_valid = stage_valid[N-1];
  assign bus.shifted   = stage_data[N-1];

`ifdef BSL_OCCUPANCY_EN
  localparam int unsigned OccW = $clog2(ADDRESS_BITS + 1);

  logic [OccW-1:0] occ_q;
  logic            in_xfer;
  logic            out_xfer;

  assign in_xfer  = bus.in_valid && ready[0];
  assign out_xfer = stage_valid[N-1] && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ_q <= occ_q + OccW'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_q <= occ_q - OccW'(1);
    end
  end

  assign occupancy = occ_q;
`endif

  // A logical shift leaves the low amt bits of the result clear.
  logic [WIDTH-1:0] last_low_mask;
  assign last_low_mask = (WIDTH'(1) << stage_amt[N-1]) - WIDTH'(1);

  a_zero_fill: assert property (@(posedge clk) disable iff (reset)
    bus.out_valid && !stage_rot[N-1] |-> (bus.shifted & last_low_mask) == '0);

  a_stall_hold: assert property (@(posedge clk) disable iff (reset)
    bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.shifted));

endmodule

// File: tb/tb_barrel_shift_l_pipe.sv
// Self-checking bench for barrel_shift_l_pipe (ADDRESS_BITS=3, WIDTH=8).
module tb_barrel_shift_l_pipe;

  localparam int unsigned AB = 3;
  localparam int unsigned W  = 2 ** AB;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  barrel_shift_l_pipe_if #(.ADDRESS_BITS(AB)) bus ();

`ifdef BSL_OCCUPANCY_EN
  logic [$clog2(AB + 1) - 1:0] occupancy;
`endif

  barrel_shift_l_pipe #(.ADDRESS_BITS(AB)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef BSL_OCCUPANCY_EN
    .occupancy (occupancy),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q [$];

  // Rotate: the upper half of the doubled word after shifting. Shift: plain truncating shift.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] n, input logic [AB-1:0] a,
                                             input logic r);
    logic [2*W-1:0] dbl;
    logic [W-1:0]   sh;
    dbl = {n, n} << a;
    sh  = n << a;
    return r ? dbl[2*W-1:W] : sh;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.num       = W'($urandom);
    bus.amt       = AB'($urandom);
    bus.rotate    = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    total++;
    if (bus.shifted !== '0) begin
      bad++;
      $display("FAIL reset_shifted: got %h want 00", bus.shifted);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    for (int t = 0; t < 5; t++) begin
      cyc();
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_accept: cycle %0d got out_valid=%b want 0", t, bus.out_valid);
      end
    end
  endtask

  logic [W-1:0]  d_num [6] = '{8'hB4, 8'hB4, 8'h81, 8'h81, 8'hB4, 8'hB4};
  logic [AB-1:0] d_amt [6] = '{3'd3, 3'd3, 3'd7, 3'd7, 3'd0, 3'd0};
  logic          d_rot [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [W-1:0]  d_exp [6] = '{8'hA5, 8'hA0, 8'hC0, 8'h80, 8'hB4, 8'hB4};

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid  = 1'b1;
      bus.num       = d_num[i];
      bus.amt       = d_amt[i];
      bus.rotate    = d_rot[i];
      bus.out_ready = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL directed_in_ready[%0d]: got %b want 1", i, bus.in_ready);
      end
      cyc();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
        cyc();
        lat++;
      end
      total++;
      if (bus.out_valid !== 1'b1 || lat != 3) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d cycles (valid=%b) want 3", i, lat,
                 bus.out_valid);
      end
      total++;
      if (bus.shifted !== d_exp[i]) begin
        bad++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, bus.shifted, d_exp[i]);
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] want;
    exp_q.delete();
    for (int t = 0; t < 16; t++) begin
      bus.in_valid  = (t < 8);
      bus.num       = W'($urandom);
      bus.amt       = AB'($urandom);
      bus.rotate    = 1'($urandom);
      bus.out_ready = 1'b1;
      #1;
      if (t < 8) begin
        total++;
        if (bus.in_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_in_ready: cycle %0d got %b want 1", t, bus.in_ready);
        end
      end
      total++;
      if (bus.out_valid !== (t >= 3 && t <= 10)) begin
        bad++;
        $display("FAIL b2b_out_valid: cycle %0d got %b want %b", t, bus.out_valid,
                 (t >= 3 && t <= 10));
      end
      if (bus.out_valid && bus.out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if (bus.shifted !== want) begin
          bad++;
          $display("FAIL b2b_result: cycle %0d got %h want %h", t, bus.shifted, want);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_shift(bus.num, bus.amt, bus.rotate));
      end
      cyc();
    end
    bus.in_valid = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_drained: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int           acc;
    int           n;
    logic         have_held;
    logic [W-1:0] held;
    logic [W-1:0] want;
    exp_q.delete();
    acc       = 0;
    have_held = 1'b0;
    held      = '0;
    for (int t = 0; t < 6; t++) begin
      bus.in_valid  = 1'b1;
      bus.num       = W'($urandom);
      bus.amt       = AB'($urandom);
      bus.rotate    = 1'($urandom);
      bus.out_ready = 1'b0;
      #1;
      total++;
      if (bus.in_ready !== (t < 3)) begin
        bad++;
        $display("FAIL bp_in_ready: cycle %0d got %b want %b", t, bus.in_ready, (t < 3));
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_shift(bus.num, bus.amt, bus.rotate));
        acc++;
      end
      if (bus.out_valid) begin
        if (have_held) begin
          total++;
          if (bus.shifted !== held) begin
            bad++;
            $display("FAIL bp_stable: cycle %0d got %h want %h", t, bus.shifted, held);
          end
        end
        have_held = 1'b1;
        held      = bus.shifted;
      end
      cyc();
    end
    total++;
    if (acc != 3) begin
      bad++;
      $display("FAIL bp_accepted: got %0d want 3", acc);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
    end
    n = 0;
    for (int t = 0; t < 10; t++) begin
      if (bus.out_valid) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n++;
        total++;
        if (bus.shifted !== want) begin
          bad++;
          $display("FAIL bp_drain: item %0d got %h want %h", n, bus.shifted, want);
        end
      end
      cyc();
    end
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL bp_drain_count: got %0d want 3", n);
    end
  endtask

  task automatic test_reset_midflight();
    int           lat;
    logic [W-1:0] want;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      bus.in_valid = 1'b1;
      bus.num      = W'($urandom);
      bus.amt      = AB'($urandom);
      bus.rotate   = 1'($urandom);
      cyc();
    end
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    cyc();
    reset = 1'b0;
    for (int t = 0; t < 6; t++) begin
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midreset_stale: cycle %0d got out_valid=%b want 0", t, bus.out_valid);
      end
      cyc();
    end
    bus.in_valid = 1'b1;
    bus.num      = W'($urandom);
    bus.amt      = AB'($urandom);
    bus.rotate   = 1'($urandom);
    want         = ref_shift(bus.num, bus.amt, bus.rotate);
    cyc();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      cyc();
      lat++;
    end
    total++;
    if (bus.out_valid !== 1'b1 || lat != 3 || bus.shifted !== want) begin
      bad++;
      $display("FAIL midreset_after: got %h in %0d cycles want %h in 3", bus.shifted, lat, want);
    end
    cyc();
  endtask

  task automatic test_random();
    logic         prev_stall;
    logic [W-1:0] prev_data;
    logic [W-1:0] want;
    logic         want_ready;
    exp_q.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int t = 0; t < 400; t++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.num       = W'($urandom);
      bus.amt       = AB'($urandom);
      bus.rotate    = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      #1;
      want_ready = (exp_q.size() < AB) || bus.out_ready;
      total++;
      if (bus.in_ready !== want_ready) begin
        bad++;
        $display("FAIL rnd_in_ready: cycle %0d got %b want %b", t, bus.in_ready, want_ready);
      end
`ifdef BSL_OCCUPANCY_EN
      total++;
      if (int'(occupancy) != exp_q.size() || occupancy > AB) begin
        bad++;
        $display("FAIL rnd_occupancy: cycle %0d got %0d want %0d", t, occupancy, exp_q.size());
      end
`endif
      if (prev_stall) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.shifted !== prev_data) begin
          bad++;
          $display("FAIL rnd_stall_hold: cycle %0d got %b/%h want 1/%h", t, bus.out_valid,
                   bus.shifted, prev_data);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.shifted;
      if (bus.out_valid && bus.out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if (bus.shifted !== want) begin
          bad++;
          $display("FAIL rnd_result: cycle %0d got %h want %h", t, bus.shifted, want);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_shift(bus.num, bus.amt, bus.rotate));
      end
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (bus.out_valid) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if (bus.shifted !== want) begin
          bad++;
          $display("FAIL rnd_drain: got %h want %h", bus.shifted, want);
        end
      end
      cyc();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rnd_lost: got %0d undelivered want 0", exp_q.size());
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.num       = '0;
    bus.amt       = '0;
    bus.rotate    = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
